// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU boot path: loader state encoding and word/byte widths.
package cpu_pkg;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam logic [31:0] DEFAULT_ENTRY = 32'd128;

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, CSUM, BOOT, DONE, ERR
  } state_t;
endpackage

// File: rtl/prog_loader_asm.sv
// Little-endian byte-to-word assembler with a running XOR over every byte it accepts.
module prog_loader_asm
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              last_byte,
  output logic              word_valid,
  output logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] csum
);
  logic [1:0]        cnt_p0;
  logic              vld_p1;
  logic [WORD_W-1:0] word_p1;
  logic [BYTE_W-1:0] csum_p1;

  assign last_byte  = (cnt_p0 == 2'd3);
  assign word_valid = vld_p1;
  assign word       = word_p1;
  assign csum       = csum_p1;

  // p0 -> p1: shift bytes in from the top so the first byte lands in bits [7:0]
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0  <= 2'd0;
      vld_p1  <= 1'b0;
      word_p1 <= '0;
      csum_p1 <= '0;
    end else if (clear) begin
      cnt_p0  <= 2'd0;
      vld_p1  <= 1'b0;
      csum_p1 <= '0;
    end else begin
      vld_p1 <= byte_en && last_byte;
      if (byte_en) begin
        cnt_p0  <= cnt_p0 + 2'd1;
        word_p1 <= {byte_data, word_p1[WORD_W-1:BYTE_W]};
        csum_p1 <= csum_p1 ^ byte_data;
      end
    end
  end
endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a length/data/checksum byte frame, writes instruction
// memory from base_addr upward, then presents entryPoint and strobes INT to start the core.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int MAX_WORDS  = 1024,
  parameter int INT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] base_addr,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [WORD_W-1:0] entryPoint,
  output logic              INT,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_t            state_q, state_d;
  logic [WORD_W-1:0] base_q, entry_q;
  logic [15:0]       len_q, idx_q;
  logic [3:0]        int_cnt_q;
  logic              accept, arm, asm_en, last_byte, word_valid;
  logic [WORD_W-1:0] word;
  logic [BYTE_W-1:0] csum;
  logic [15:0]       n_full;

  assign accept = byte_valid && byte_ready;
  assign arm    = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
  assign asm_en = accept && (state_q == DATA);
  assign n_full = {byte_data, len_q[7:0]};

  prog_loader_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (arm),
    .byte_en    (asm_en),
    .byte_data  (byte_data),
    .last_byte  (last_byte),
    .word_valid (word_valid),
    .word       (word),
    .csum       (csum)
  );

  // The last word's 4th byte moves straight to CSUM; its write issues there one cycle later.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) state_d = LEN_LO;
      LEN_LO:          if (accept) state_d = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if ({16'd0, n_full} > 32'(MAX_WORDS)) state_d = ERR;
          else if (n_full == 16'd0)             state_d = CSUM;
          else                                  state_d = DATA;
        end
      end
      DATA:   if (accept && last_byte && idx_q == len_q - 16'd1) state_d = CSUM;
      CSUM:   if (accept) state_d = (byte_data == csum) ? BOOT : ERR;
      BOOT:   if (int_cnt_q == 4'(INT_CYCLES - 1)) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    case (state_q)
      LEN_LO, LEN_HI, DATA, CSUM: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      BOOT:    busy = 1'b1;
      default: ;
    endcase
  end

  assign INT        = (state_q == BOOT);
  assign done       = (state_q == DONE) && !start;
  assign err        = (state_q == ERR) && !start;
  assign mem_we     = word_valid;
  assign mem_addr   = base_q + {14'd0, idx_q, 2'b00};
  assign mem_wdata  = word;
  assign entryPoint = entry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      entry_q   <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      int_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (arm) begin
        base_q    <= base_addr;
        idx_q     <= '0;
        int_cnt_q <= '0;
      end else begin
        if (word_valid) idx_q <= idx_q + 16'd1;
        if (state_q == BOOT) int_cnt_q <= int_cnt_q + 4'd1;
      end
      if (accept && state_q == LEN_LO) len_q[7:0]  <= byte_data;
      if (accept && state_q == LEN_HI) len_q[15:8] <= byte_data;
      if (accept && state_q == CSUM && byte_data == csum) entry_q <= base_q;
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of frames driven byte by byte, memory writes checked against a queue.
module tb_prog_loader;
  localparam int MAXW = 1024;
  localparam int INTC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, mem_we, INT, busy, done, err;
  logic [31:0] mem_addr, mem_wdata, entryPoint;

  prog_loader #(.MAX_WORDS(MAXW), .INT_CYCLES(INTC)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .entryPoint (entryPoint),
    .INT        (INT),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_rst;
    logic [31:0] base;
    logic [15:0] len;
    logic [63:0] w;
    bit          good_csum;
    bit          rnd;
  } vec_t;

  vec_t        vecs[6];
  logic [63:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          int_seen = 0;
  logic [31:0] exp_entry = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Write scoreboard and per-cycle exclusivity of mem_we / INT / err.
  always @(negedge clk) begin
    logic [63:0] e;
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write actual=%0h:%0h required=none", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr_data", {mem_addr, mem_wdata}, e);
      end
    end
    if (INT) int_seen++;
    if (mem_we || INT || err)
      chk("we_int_err_exclusive", 64'(int'(mem_we) + int'(INT) + int'(err)), 64'd1);
  end

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int guard = 0;
    while (rnd && $urandom_range(1, 0) == 1) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      tests++;
      fails++;
      $display("FAIL byte_ready_timeout actual=0 required=1");
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {26'd0, mem_we, INT, busy, done, err, byte_ready, entryPoint}, 64'd0);
    chk("reset_mem", {mem_addr, mem_wdata}, 64'd0);
    rst       = 1'b0;
    exp_entry = '0;
  endtask

  task automatic do_start(input logic [31:0] base);
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    int_seen  = 0;
    #1;
    chk("start_clears_flags", {62'd0, done, err}, 64'd0);
    @(negedge clk);
    start     = 1'b0;
    base_addr = 32'hDEAD_BEEF;
  endtask

  task automatic run_vec(input int i);
    vec_t       v;
    logic [7:0] cs;
    int         guard;
    bit         ok_len, exp_done;
    v        = vecs[i];
    cs       = 8'h00;
    guard    = 0;
    ok_len   = (int'(v.len) <= MAXW);
    exp_done = ok_len && v.good_csum;
    if (v.do_rst) do_reset();
    do_start(v.base);
    if (ok_len)
      for (int k = 0; k < int'(v.len); k++) begin
        exp_q.push_back({v.base + 32'(4 * k), v.w[32*k +: 32]});
        for (int b = 0; b < 4; b++) cs ^= v.w[32*k + 8*b +: 8];
      end
    send_byte(v.len[7:0], v.rnd);
    send_byte(v.len[15:8], v.rnd);
    if (ok_len) begin
      for (int k = 0; k < int'(v.len); k++)
        for (int b = 0; b < 4; b++) send_byte(v.w[32*k + 8*b +: 8], v.rnd);
      send_byte(v.good_csum ? cs : 8'h00, v.rnd);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    while (!(done || err) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (exp_done) exp_entry = v.base;
    chk($sformatf("v%0d_done", i), 64'(done), 64'(exp_done));
    chk($sformatf("v%0d_err", i), 64'(err), 64'(!exp_done));
    chk($sformatf("v%0d_int_cycles", i), 64'(int_seen), exp_done ? 64'(INTC) : 64'd0);
    chk($sformatf("v%0d_entry", i), 64'(entryPoint), 64'(exp_entry));
    chk($sformatf("v%0d_idle_ready_busy", i), {62'd0, byte_ready, busy}, 64'd0);
    chk($sformatf("v%0d_writes_left", i), 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    vecs[0] = '{do_rst: 1'b1, base: 32'd128, len: 16'd2, w: 64'h8C020004_20010005, good_csum: 1'b1, rnd: 1'b0};
    vecs[1] = '{do_rst: 1'b1, base: 32'd128, len: 16'd2, w: 64'h8C020004_20010005, good_csum: 1'b0, rnd: 1'b0};
    vecs[2] = '{do_rst: 1'b0, base: 32'h400, len: 16'd0, w: 64'd0, good_csum: 1'b1, rnd: 1'b0};
    vecs[3] = '{do_rst: 1'b0, base: 32'd128, len: 16'h0401, w: 64'd0, good_csum: 1'b1, rnd: 1'b0};
    vecs[4] = '{do_rst: 1'b0, base: 32'd128, len: 16'd2, w: 64'h8C020004_20010005, good_csum: 1'b1, rnd: 1'b1};
    vecs[5] = '{do_rst: 1'b0, base: 32'hFFFF_FFFC, len: 16'd2, w: 64'h8C020004_20010005, good_csum: 1'b1, rnd: 1'b0};

    for (int i = 0; i < 6; i++) run_vec(i);

    // Reset in the middle of the second word: only word 0 may ever be written.
    do_reset();
    do_start(32'd128);
    exp_q.push_back({32'd128, 32'h20010005});
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    rst        = 1'b1;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_outputs", {26'd0, mem_we, INT, busy, done, err, byte_ready, entryPoint}, 64'd0);
    chk("abort_writes_left", 64'(exp_q.size()), 64'd0);
    rst       = 1'b0;
    exp_entry = '0;
    repeat (5) @(negedge clk);
    chk("abort_stays_idle", {61'd0, busy, INT, byte_ready}, 64'd0);
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
